powlib_busarb_lane: RTL
=======================

// Module: powlib_busarb_lane
// PURPOSE
//  Single-clock N-writer to 1-reader bus lane. Decodes each writer's address against one window,
//  arbitrates in-window words (fixed-priority or round-robin, optional burst lock) into an internal
//  output FIFO, and drops and counts out-of-window words. It is the next-generation arbitration lane
//  for same-clock crossbars, with fairness, burst hold and error accounting.
// PARAMETERS
//  B_WRS   4    number of writer channels (>=1)
//  B_AW    8    address width
//  B_DW    32   data width
//  D       8    output FIFO depth (power of 2, >=2)
//  ARB     1    0 = fixed priority (lowest index wins); 1 = round-robin
//  BURST   1    maximum consecutive beats granted to one owner (1 = no lock)
//  B_BASE  0    window base address
//  B_SIZE  255  window span; window is [B_BASE, B_BASE+B_SIZE], inclusive
//  EW      8    error counter width
// PORTS
//  clk      in   1            clock
//  rst      in   1            asynchronous reset, active-low
//  wrdatas  in   B_WRS*B_DW   writer data, channel i at [i*B_DW+:B_DW]
//  wraddrs  in   B_WRS*B_AW   writer address, channel i at [i*B_AW+:B_AW]
//  wrvlds   in   B_WRS        writer valid
//  wrrdys   out  B_WRS        writer ready (combinational); a beat transfers on vld&&rdy
//  rddata   out  B_DW         head-of-FIFO data
//  rdaddr   out  B_AW         head-of-FIFO address
//  rdvld    out  1            FIFO not empty
//  rdrdy    in   1            reader ready; pop on rdvld&&rdrdy
//  count    out  log2(D)+1    FIFO occupancy
//  errcnt   out  EW           saturating count of dropped out-of-window beats
// BEHAVIOUR
//  Reset (rst=0, asynchronous): count=0, rdvld=0, errcnt=0, RR pointer=0, state=ARB, wrrdys=0.
//  Window: inwin[i] = (a>=B_BASE)&&(a<=B_BASE+B_SIZE), computed B_AW+1 bits wide so the upper bound never wraps.
//  req[i] = wrvlds[i] && inwin[i]. Out-of-window beats: wrrdys[i]=1 unconditionally (outside reset),
//   beat is dropped, errcnt += popcount of dropped beats that cycle, saturating at all-ones.
//  full = (count==D). No grant while full; a pop in the same cycle does NOT permit a push (no bypass).
//  At most one in-window grant per cycle; wrrdys[i] = grant[i] || (wrvlds[i] && !inwin[i]).
//  ARB=0: grant the lowest-index req. ARB=1: search starts at pointer p and wraps; after an accept
//   from channel i, p <= (i+1) mod B_WRS. p holds when nothing is accepted.
//  FSM (only when BURST>1):
//   ARB : grant per policy. On accept from i: owner<=i, beats<=1. Go LOCK if BURST>1, else stay.
//   LOCK: if req[owner]: grant only owner (if !full). Others get no in-window grant.
//         On accept: beats+1; if beats+1==BURST, go ARB.
//         If !req[owner]: release this cycle, grant per policy, apply ARB-state rules for the accept.
//  Full in LOCK with req[owner]: state and beats hold; no grant.
//  FIFO: push order equals grant order. rdvld/rddata/rdaddr are driven from registered head state.
//   A beat accepted at edge N is visible on rdvld after edge N when the FIFO was empty (1-cycle latency).
//  Push and pop together: count unchanged; pointers wrap modulo D.
//  Reset mid-burst or mid-stream: FIFO contents are discarded; state returns to ARB, p=0.
//  rddata/rdaddr are don't-care while rdvld=0.
// TESTING
//  1 Reset: hold rst=0 with wrvlds=4'hF -> wrrdys=0, rdvld=0, count=0, errcnt=0. Release -> ch0 is granted first.
//  2 RR fairness (ARB=1, BURST=1, rdrdy=1): all 4 channels valid in-window for 8 cycles ->
//    grants 0,1,2,3,0,1,2,3; rddata order matches. With ARB=0 -> ch0 every cycle.
//  3 Burst lock (BURST=3): ch1 and ch2 valid -> 3 ch1 beats, then ch2. ch1 drops vld after 1 beat ->
//    release, and ch2 is granted that same cycle.
//  4 Full/backpressure (D=8, rdrdy=0): 10 beats offered -> 8 accepted, count=8, wrrdys=0.
//    rdrdy=1 for one cycle -> count=7, and no push occurs in that cycle.
//  5 Window (B_BASE=8'h10, B_SIZE=8'h0F): addrs 8'h0F, 8'h10, 8'h1F, 8'h20 -> 8'h10 and 8'h1F are queued;
//    errcnt=2; the dropped beats see wrrdys=1 even while the FIFO is full.
//  6 errcnt saturation (EW=2): 5 out-of-window beats -> errcnt stays 2'b11.

Source files
------------

// File: rtl/powlib_busarb_lane.sv
// powlib_busarb_lane: N-writer to 1-reader same-clock bus lane.
// Each writer's address is decoded against one window. In-window beats are arbitrated
// (fixed priority or round-robin, with optional burst lock) into an output FIFO.
// Out-of-window beats are accepted immediately, dropped and counted in a saturating counter.
module powlib_busarb_lane #(
   parameter int B_WRS  = 4,
   parameter int B_AW   = 8,
   parameter int B_DW   = 32,
   parameter int D      = 8,
   parameter int ARB    = 1,
   parameter int BURST  = 1,
   parameter int B_BASE = 0,
   parameter int B_SIZE = 255,
   parameter int EW     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [B_WRS*B_DW-1:0]   wrdatas,
   input  logic [B_WRS*B_AW-1:0]   wraddrs,
   input  logic [B_WRS-1:0]        wrvlds,
   output logic [B_WRS-1:0]        wrrdys,
   output logic [B_DW-1:0]         rddata,
   output logic [B_AW-1:0]         rdaddr,
   output logic                    rdvld,
   input  logic                    rdrdy,
   output logic [$clog2(D):0]      count,
   output logic [EW-1:0]           errcnt
);

   localparam int PW   = (B_WRS > 1) ? $clog2(B_WRS) : 1;
   localparam int FW   = $clog2(D);
   localparam int BW   = $clog2(BURST + 1);
   localparam int CW   = EW + $clog2(B_WRS + 1) + 1;
   localparam logic USE_LOCK = (BURST > 1);

   // Window bounds carry one extra bit so BASE+SIZE never wraps.
   localparam logic [B_AW:0] WIN_LO = (B_AW+1)'(B_BASE);
   localparam logic [B_AW:0] WIN_HI = (B_AW+1)'(B_BASE + B_SIZE);

   localparam logic [0:0] ST_ARB  = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [B_WRS-1:0]       inwin, req, drop, cand, grant;
   logic                   hold, full, accept, push, pop;
   logic [PW-1:0]          gidx, p, owner;
   logic [BW-1:0]          beats;
   logic [0:0]             state;
   logic [B_AW+B_DW-1:0]   mem [D];
   logic [B_AW+B_DW-1:0]   wdat;
   logic [FW-1:0]          wr_ptr, rd_ptr;
   logic [CW-1:0]          ndrop, esum;
   logic [EW-1:0]          enext;

   // Address window decode per writer.
   always_comb begin
      logic [B_AW:0] a_ext;
      a_ext = '0;
      inwin = '0;
      for (int unsigned i = 0; i < B_WRS; i++) begin
         a_ext    = {1'b0, wraddrs[i*B_AW +: B_AW]};
         inwin[i] = (a_ext >= WIN_LO) && (a_ext <= WIN_HI);
      end
   end

   assign req    = wrvlds & inwin;
   assign drop   = wrvlds & ~inwin;
   assign full   = (count == (FW+1)'(D));
   assign hold   = (state == ST_LOCK) && req[owner];
   assign accept = |grant;
   assign push   = accept;
   assign pop    = rdvld && rdrdy;

   // Candidate set: only the burst owner while it keeps requesting, else every requester.
   always_comb begin
      cand = req;
      if (hold) begin
         cand        = '0;
         cand[owner] = 1'b1;
      end
   end

   // Single-grant selection: lowest index, or rotating search starting at p.
   always_comb begin
      int unsigned idx;
      logic        found;
      idx   = 0;
      found = 1'b0;
      grant = '0;
      gidx  = '0;
      if (!full) begin
         for (int unsigned k = 0; k < B_WRS; k++) begin
            idx = (ARB != 0) ? ((32'(p) + k) % B_WRS) : k;
            if (!found && cand[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               gidx       = PW'(idx);
            end
         end
      end
   end

   // Writer handshake: dropped beats are always taken; nothing is ready during reset.
   assign wrrdys = rst ? (grant | drop) : '0;

   // Mux the granted writer's beat into the FIFO write word.
   always_comb begin
      wdat = '0;
      for (int unsigned i = 0; i < B_WRS; i++) begin
         if (grant[i]) wdat = {wraddrs[i*B_AW +: B_AW], wrdatas[i*B_DW +: B_DW]};
      end
   end

   // Arbitration state: round-robin pointer, burst owner and beat count.
   // A lapse in the owner's request releases the lock in the same cycle, so a new
   // owner granted that cycle starts a fresh burst rather than continuing the old one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_ARB;
         owner <= '0;
         beats <= '0;
         p     <= '0;
      end else if (accept) begin
         if (ARB != 0) p <= (gidx == PW'(B_WRS - 1)) ? '0 : gidx + 1'b1;
         if (hold) begin
            beats <= beats + 1'b1;
            if (beats == BW'(BURST - 1)) state <= ST_ARB;
         end else begin
            owner <= gidx;
            beats <= BW'(1);
            state <= USE_LOCK ? ST_LOCK : ST_ARB;
         end
      end else if (!hold) begin
         state <= ST_ARB;
      end
   end

   // FIFO storage; contents are meaningful only between rd_ptr and wr_ptr.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdat;
   end

   // FIFO pointers and occupancy; push is already blocked while full.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdvld            = (count != '0);
   assign {rdaddr, rddata} = mem[rd_ptr];

   // Saturating sum of this cycle's dropped beats into the error count.
   always_comb begin
      ndrop = '0;
      for (int unsigned i = 0; i < B_WRS; i++) ndrop = ndrop + CW'(drop[i]);
      esum  = CW'(errcnt) + ndrop;
      enext = (esum > CW'({EW{1'b1}})) ? '1 : esum[EW-1:0];
   end

   // Error counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) errcnt <= '0;
      else      errcnt <= enext;
   end

endmodule
